line_memory_responder: RTL and testbench

LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

---
 rtl/line_memory_responder_if.sv | 23 ++
 rtl/line_memory_responder.sv | 116 +++++++++++
 tb/tb_line_memory_responder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_memory_responder_if.sv
// Request/response bundle between a line initiator and the line memory responder.
// The initiator holds enable_i until it sees the one-cycle ack_o pulse.
interface line_memory_responder_if;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;
  logic [15:0]  rd_count_o;
  logic [15:0]  wr_count_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o, rd_count_o, wr_count_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o, rd_count_o, wr_count_o
  );
endinterface

// File: rtl/line_memory_responder.sv
// Fixed-latency 256-bit line memory: accepts one request in IDLE, answers with a
// registered ack pulse exactly LATENCY cycles after acceptance.
module line_memory_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input logic                    clk_i,
  input logic                    rst_i,
  line_memory_responder_if.slave bus
);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state_reg, state_next;
  logic [7:0]         lat_cnt_reg, lat_cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [255:0]       wdata_reg, wdata_next;
  logic               write_reg, write_next;
  logic               ack_reg;
  logic [255:0]       rdata_reg;
  logic               complete;
  logic [IDX_W-1:0]   addr_idx;
  logic               addr_unused;

  logic [255:0] memory [DEPTH];

  assign addr_idx    = IDX_W'(32'(bus.addr_i[13:5]) % DEPTH);
  assign addr_unused = ^{bus.addr_i[31:14], bus.addr_i[4:0]};

  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    idx_next     = idx_reg;
    wdata_next   = wdata_reg;
    write_next   = write_reg;
    complete     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.enable_i) begin
          idx_next     = addr_idx;
          wdata_next   = bus.data_i;
          write_next   = bus.write_i;
          lat_cnt_next = LAT_LOAD;
          // LATENCY of 1 skips WAIT so the ack still lands one cycle later
          state_next   = (LAT_LOAD == 8'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        lat_cnt_next = lat_cnt_reg - 8'd1;
        if (lat_cnt_reg <= 8'd1) begin
          lat_cnt_next = 8'd0;
          state_next   = ACK;
        end
      end
      ACK: begin
        complete   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= 8'd0;
      idx_reg     <= '0;
      wdata_reg   <= '0;
      write_reg   <= 1'b0;
      ack_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
      idx_reg     <= idx_next;
      wdata_reg   <= wdata_next;
      write_reg   <= write_next;
      ack_reg     <= complete;
      if (complete && !write_reg) begin
        rdata_reg <= memory[idx_reg];
      end
    end
  end

  // Storage has no reset so preloaded contents survive rst_i
  always_ff @(posedge clk_i) begin
    if (complete && write_reg && !rst_i) begin
      memory[idx_reg] <= wdata_reg;
    end
  end

  // Index 0 counts reads, index 1 counts writes; both stick at all-ones
  for (genvar gi = 0; gi < 2; gi++) begin : g_count
    localparam bit IS_WRITE = (gi == 1);
    logic [15:0] cnt_reg;
    logic        hit;

    assign hit = complete && (write_reg == IS_WRITE);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_reg <= 16'd0;
      end else if (hit && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign bus.ack_o      = ack_reg;
  assign bus.data_o     = rdata_reg;
  assign bus.busy_o     = (state_reg != IDLE);
  assign bus.rd_count_o = g_count[0].cnt_reg;
  assign bus.wr_count_o = g_count[1].cnt_reg;
endmodule

// File: tb/tb_line_memory_responder.sv
// Self-checking bench: transaction-level reference model for a LATENCY=10 instance
// plus literal checks, and a LATENCY=1 instance for back-to-back timing.
module tb_line_memory_responder;
  localparam int LAT_A = 10;
  localparam int DEPTH = 512;

  logic clk;
  logic rst;
  int   tests  = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_txn  = 0;
  bit   chk_on = 0;

  line_memory_responder_if bus_a ();
  line_memory_responder_if bus_b ();

  line_memory_responder #(.LATENCY(LAT_A), .DEPTH(DEPTH)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  line_memory_responder #(.LATENCY(1), .DEPTH(DEPTH)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the outputs of dut_a must be, per transaction timing
  logic [255:0] ref_mem [DEPTH];
  bit           m_busy = 0;
  int           m_due  = 0;
  int           m_idx  = 0;
  bit           m_wr   = 0;
  logic [255:0] m_data = '0;
  logic         exp_ack  = 1'b0;
  logic         exp_busy = 1'b0;
  logic [255:0] exp_data = '0;
  logic [15:0]  exp_rd   = 16'd0;
  logic [15:0]  exp_wr   = 16'd0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        m_busy   = 0;
        exp_ack  = 1'b0;
        exp_data = '0;
        exp_rd   = 16'd0;
        exp_wr   = 16'd0;
      end else begin
        exp_ack = 1'b0;
        if (m_busy && cyc == m_due) begin
          if (m_wr) begin
            ref_mem[m_idx] = m_data;
            if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
          end else begin
            exp_data = ref_mem[m_idx];
            if (exp_rd != 16'hFFFF) exp_rd = exp_rd + 16'd1;
          end
          exp_ack = 1'b1;
          m_busy  = 0;
        end else if (!m_busy && bus_a.enable_i) begin
          m_idx  = int'(bus_a.addr_i[13:5]) % DEPTH;
          m_wr   = bus_a.write_i;
          m_data = bus_a.data_i;
          m_due  = cyc + LAT_A;
          m_busy = 1;
        end
      end
      exp_busy = m_busy;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("ack", bus_a.ack_o, exp_ack);
        chk("busy", bus_a.busy_o, exp_busy);
        chk("data_o", bus_a.data_o, exp_data);
        chk("rd_count", bus_a.rd_count_o, exp_rd);
        chk("wr_count", bus_a.wr_count_o, exp_wr);
      end
    end
  end

  task automatic req_a(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                       input bit scramble, output int lat, output logic [255:0] rdata);
    int t0;
    bit got;
    @(posedge clk);
    #2;
    bus_a.write_i  = wr;
    bus_a.addr_i   = addr;
    bus_a.data_i   = data;
    bus_a.enable_i = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    got   = 0;
    lat   = -1;
    rdata = '0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (bus_a.ack_o) begin
        got            = 1;
        lat            = cyc - t0;
        rdata          = bus_a.data_o;
        bus_a.enable_i = 1'b0;
      end else if (scramble) begin
        bus_a.addr_i  = $urandom();
        bus_a.data_i  = rand256();
        bus_a.write_i = 1'($urandom_range(0, 1));
      end
    end
    if (!got) begin
      chk("ack_timeout", 1'b0, 1'b1);
      bus_a.enable_i = 1'b0;
    end
    n_txn++;
    $display("[TB] txn %0d wr=%0d addr=%h lat=%0d data_o=%h", n_txn, wr, addr, lat, rdata[63:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [255:0] rd;
    logic [255:0] v;
    bit           seen;
    int           nmis;
    logic         ack_pat  [6];
    logic         busy_pat [6];

    rst = 1'b1;
    bus_a.enable_i = 1'b0; bus_a.write_i = 1'b0; bus_a.addr_i = '0; bus_a.data_i = '0;
    bus_b.enable_i = 1'b0; bus_b.write_i = 1'b0; bus_b.addr_i = '0; bus_b.data_i = '0;

    for (int i = 0; i < DEPTH; i++) begin
      v = rand256();
      case (i)
        0: v = 256'h5;
        1: v = 256'h11;
        2: v = 256'h22;
        3: v = 256'h33;
        default: ;
      endcase
      dut_a.memory[i] = v;
      dut_b.memory[i] = v;
      ref_mem[i]      = v;
    end

    repeat (3) @(posedge clk);
    #2;
    rst    = 1'b0;
    chk_on = 1;
    @(negedge clk);
    chk("rst_ack", bus_a.ack_o, 1'b0);
    chk("rst_busy", bus_a.busy_o, 1'b0);
    chk("rst_data", bus_a.data_o, 256'h0);
    chk("rst_wrcnt", bus_a.wr_count_o, 16'h0);

    // Write to line 3 aborted by reset four cycles after acceptance; enable held during reset
    @(posedge clk);
    #2;
    bus_a.write_i = 1'b1; bus_a.addr_i = 32'h60; bus_a.data_i = 256'hDEAD; bus_a.enable_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_busy_wait", bus_a.busy_o, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus_a.enable_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus_a.ack_o) seen = 1;
    end
    chk("abort_no_ack", seen, 1'b0);
    chk("abort_mem3", dut_a.memory[3], 256'h33);
    chk("abort_wrcnt", bus_a.wr_count_o, 16'h0);
    chk("abort_busy", bus_a.busy_o, 1'b0);

    req_a(1'b0, 32'h0, 256'h0, 0, lat, rd);
    chk("rd0_latency", lat, 10);
    chk("rd0_data", rd, 256'h5);
    chk("rd0_rdcnt", bus_a.rd_count_o, 16'd1);
    @(negedge clk);
    chk("rd0_pulse_width", bus_a.ack_o, 1'b0);

    req_a(1'b1, 32'h400, 256'hA5A5, 0, lat, rd);
    chk("wr400_latency", lat, 10);
    chk("wr400_mem32", dut_a.memory[32], 256'hA5A5);
    chk("wr400_dout_hold", bus_a.data_o, 256'h5);
    req_a(1'b0, 32'h400, 256'h0, 0, lat, rd);
    chk("rd400_data", rd, 256'hA5A5);

    req_a(1'b1, 32'hE0, 256'h1234, 1, lat, rd);
    req_a(1'b0, 32'hE0, 256'h0, 0, lat, rd);
    chk("scramble_wr_data", rd, 256'h1234);
    req_a(1'b0, 32'h40, 256'h0, 1, lat, rd);
    chk("scramble_rd_data", rd, 256'h22);

    req_a(1'b0, 32'h4000_0020, 256'h0, 0, lat, rd);
    chk("highbits_data", rd, 256'h11);
    chk("dir_rdcnt", bus_a.rd_count_o, 16'd5);
    chk("dir_wrcnt", bus_a.wr_count_o, 16'd2);

    // LATENCY=1 back-to-back reads of lines 1 and 2, enable held across the first ack
    ack_pat  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    busy_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    @(posedge clk);
    #2;
    bus_b.addr_i = 32'h20; bus_b.write_i = 1'b0; bus_b.enable_i = 1'b1;
    @(posedge clk);
    #1;
    bus_b.addr_i = 32'h40;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat1_ack_T%0d", k), bus_b.ack_o, ack_pat[k]);
      chk($sformatf("lat1_busy_T%0d", k), bus_b.busy_o, busy_pat[k]);
      if (k == 1) chk("lat1_data_first", bus_b.data_o, 256'h11);
      if (k == 2) bus_b.enable_i = 1'b0;
      if (k == 3) begin
        chk("lat1_data_second", bus_b.data_o, 256'h22);
        chk("lat1_rdcnt", bus_b.rd_count_o, 16'd2);
      end
    end
    n_txn++;
    $display("[TB] txn %0d lat1 back-to-back reads 0x20,0x40", n_txn);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom();
      a[13:5] = 9'($urandom_range(0, 7));
      req_a(1'($urandom_range(0, 1)), a, rand256(), bit'($urandom_range(0, 1)), lat, rd);
      chk("rand_latency", lat, LAT_A);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    nmis = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dut_a.memory[i] !== ref_mem[i]) nmis++;
    end
    chk("final_mem_mismatches", nmis, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
